// File: rtl/ajit_acb_read_engine.sv
// ============================================================================
// Module   : ajit_acb_read_engine
// Purpose  : Reads a block of 64-bit doublewords over the ACB memory pipes and
//            accumulates their sum.
// Options  : ACB_ERR_ABORT_EN - an errored response aborts the run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ajit_acb_read_engine #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [35:0]        base_addr,
    input  logic [CNT_W-1:0]   word_count,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [63:0]        sum,
    output logic [109:0]       ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
    input  logic               ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
    output logic               ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
    input  logic [64:0]        ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
    input  logic               ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
    output logic               ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t             state_q;
    logic [35:0]        addr_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [63:0]        sum_q;
    logic               error_q;
    logic               done_q;
    logic               busy_q;
    logic [109:0]       req_data_q;

    logic [35:0]        base_aligned;
    logic [35:0]        addr_d;
    logic               resp_err;
    logic [63:0]        resp_data;
    logic               abort;

    assign base_aligned = base_addr & 36'hF_FFFF_FFF8;
    assign addr_d       = addr_q + 36'd8;
    assign resp_err     = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[64];
    assign resp_data    = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[63:0];

`ifdef ACB_ERR_ABORT_EN
    assign abort = resp_err;
`else
    assign abort = 1'b0;
`endif

    // Read request: lock=0, read=1, full byte mask, no write data.
    function automatic logic [109:0] req_word(input logic [35:0] a);
        return {1'b0, 1'b1, 8'hFF, a, 64'h0};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            sum_q       <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            req_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sum_q   <= '0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (word_count != '0) begin
                            addr_q      <= base_aligned;
                            remaining_q <= word_count;
                            req_data_q  <= req_word(base_aligned);
                            state_q     <= ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req)
                        state_q <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req) begin
                        addr_q      <= addr_d;
                        remaining_q <= remaining_q - CNT_W'(1);
                        error_q     <= error_q | resp_err;
                        if (!abort)
                            sum_q <= sum_q + resp_data;
                        if (abort || remaining_q == CNT_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            req_data_q <= req_word(addr_d);
                            state_q    <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;
    assign sum   = sum_q;
    assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data = req_data_q;
    assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack =
        (state_q == ISSUE) && ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
    assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack =
        (state_q == WAIT_RESP) && ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;

endmodule

`default_nettype wire

// File: tb/tb_ajit_acb_read_engine.sv
// ============================================================================
// Module   : tb_ajit_acb_read_engine
// Purpose  : Directed and randomised bench for ajit_acb_read_engine with a
//            transaction-level memory/sum model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ajit_acb_read_engine;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [35:0]  base_addr = '0;
    logic [15:0]  word_count = '0;
    logic         busy, done, error;
    logic [63:0]  sum;
    logic [109:0] rq_data;
    logic         rq_req = 1'b0;
    logic         rq_ack;
    logic [64:0]  rs_data = '0;
    logic         rs_req = 1'b0;
    logic         rs_ack;

    int checks   = 0;
    int failures = 0;
    int req_cnt  = 0;

    ajit_acb_read_engine #(.CNT_W(16)) dut (
        .clk                                          (clk),
        .reset                                        (reset),
        .start                                        (start),
        .base_addr                                    (base_addr),
        .word_count                                   (word_count),
        .busy                                         (busy),
        .done                                         (done),
        .error                                        (error),
        .sum                                          (sum),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data   (rq_data),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req    (rq_req),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack    (rq_ack),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data (rs_data),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req  (rs_req),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack  (rs_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rq_ack && rq_req) req_cnt <= req_cnt + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] gen(input int mode, input int i);
        case (mode)
            0:       return 64'(i + 1);
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'd5;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One complete run; the memory side is played here, transaction by transaction.
    task automatic run(input string tag, input logic [35:0] base, input int n,
                       input int stall_max, input int mode, input int err_idx,
                       input bit extra_start);
        logic [63:0] esum = '0;
        bit          eerr = 1'b0;
        logic [35:0] ea   = {base[35:3], 3'b000};
        int          ereq = 0;
        int          t;
        int          r0;
        int          st;
        bit          stop = 1'b0;
        logic [63:0] d;
        bit          e;

        @(negedge clk);
        r0 = req_cnt;
        base_addr  = base;
        word_count = 16'(n);
        start      = 1'b1;
        @(posedge clk);
        t = 1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_after_start"}, busy, 1'b1);

        for (int i = 0; i < n && !stop; i++) begin
            st = (stall_max == 0) ? 0 : $urandom_range(0, stall_max);
            if (extra_start && i == 1 && st == 0) st = 1;
            repeat (st) begin
                if (extra_start && i == 1) start = 1'b1;
                @(posedge clk); t++;
                @(negedge clk);
                start = 1'b0;
            end
            rq_req = 1'b1;
            #1;
            chk({tag, ".req_ack"}, rq_ack, 1'b1);
            chk({tag, ".req_word"}, rq_data, {1'b0, 1'b1, 8'hFF, ea, 64'h0});
            @(posedge clk); t++;
            @(negedge clk);
            rq_req = 1'b0;
            ereq++;

            st = (stall_max == 0) ? 0 : $urandom_range(0, stall_max);
            repeat (st) begin
                @(posedge clk); t++;
                @(negedge clk);
            end
            d = gen(mode, i);
            e = (i == err_idx);
            rs_data = {e, d};
            rs_req  = 1'b1;
            if (extra_start && i == 0) start = 1'b1;
            #1;
            chk({tag, ".resp_ack"}, rs_ack, 1'b1);
            eerr = eerr | e;
`ifdef ACB_ERR_ABORT_EN
            if (e) stop = 1'b1;
            else   esum = esum + d;
`else
            esum = esum + d;
`endif
            ea = ea + 36'd8;
            @(posedge clk); t++;
            @(negedge clk);
            rs_req = 1'b0;
            start  = 1'b0;
        end

        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".sum"}, sum, esum);
        chk({tag, ".error"}, error, eerr);
        chk({tag, ".busy_in_done"}, busy, 1'b1);
        chk({tag, ".req_count"}, req_cnt - r0, ereq);
        if (stall_max == 0) chk({tag, ".latency"}, t, 2 * ereq + 1);

        rq_req = 1'b1;
        rs_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".done_pulse"}, done, 1'b0);
        chk({tag, ".busy_idle"}, busy, 1'b0);
        chk({tag, ".acks_idle"}, {rq_ack, rs_ack}, 2'b00);
        chk({tag, ".sum_held"}, sum, esum);
        rq_req = 1'b0;
        rs_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset.outs", {busy, done, error, sum}, '0);
        chk("reset.req_data", rq_data, '0);
        rq_req = 1'b1;
        rs_req = 1'b1;
        #1;
        chk("reset.acks_forced", {rq_ack, rs_ack}, 2'b00);
        rq_req = 1'b0;
        rs_req = 1'b0;

        run("basic3", 36'h0_0000_1003, 3, 0, 0, -1, 1'b0);
        run("zero",   36'h0_0000_2000, 0, 0, 0, -1, 1'b0);
        run("wrap",   36'hF_FFFF_FFF8, 2, 0, 1, -1, 1'b0);
        run("err2",   36'h0_0000_4000, 4, 0, 2, 1,  1'b0);

        for (int k = 0; k < 6; k++) begin
            run("rand", {$urandom_range(0, 15), $urandom}, $urandom_range(1, 8), 5, 3,
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1, 1'b1);
        end

        // Reset while a response is being offered in WAIT_RESP.
        @(negedge clk);
        base_addr  = 36'h0_0000_8000;
        word_count = 16'd5;
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        rq_req = 1'b1;
        @(negedge clk);
        rq_req  = 1'b0;
        rs_data = {1'b0, 64'h1234};
        rs_req  = 1'b1;
        #1;
        chk("midreset.resp_ack_before", rs_ack, 1'b1);
        reset = 1'b1;
        #1;
        chk("midreset.busy", busy, 1'b0);
        chk("midreset.resp_ack", rs_ack, 1'b0);
        chk("midreset.sum", sum, 64'h0);
        chk("midreset.req_data", rq_data, '0);
        @(negedge clk);
        reset  = 1'b0;
        rs_req = 1'b0;
        @(negedge clk);
        chk("midreset.idle", {busy, done, error}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
